// File: rtl/burst_xfer_ctrl_if.sv
// Bundle of grant, requester and shared write-bus signals around the
// burst transfer controller. The controller uses the slave view; whatever
// drives grants, requester data and the bus sink uses the master view.
interface burst_xfer_ctrl_if #(
    parameter int DW   = 8,
    parameter int AW   = 8,
    parameter int LENW = 4
);
    logic            gnt_0;
    logic            gnt_1;
    logic [AW-1:0]   addr_0;
    logic [LENW-1:0] len_0;
    logic [DW-1:0]   data_0;
    logic [AW-1:0]   addr_1;
    logic [LENW-1:0] len_1;
    logic [DW-1:0]   data_1;
    logic            rd_0;
    logic            rd_1;
    logic            done_0;
    logic            done_1;
    logic            abort;
    logic            bus_valid;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_data;
    logic            bus_last;
    logic            bus_ready;
    logic            busy;

    modport slave (
        input  gnt_0, gnt_1, addr_0, len_0, data_0, addr_1, len_1, data_1, bus_ready,
        output rd_0, rd_1, done_0, done_1, abort, bus_valid, bus_addr, bus_data,
               bus_last, busy
    );

    modport master (
        output gnt_0, gnt_1, addr_0, len_0, data_0, addr_1, len_1, data_1, bus_ready,
        input  rd_0, rd_1, done_0, done_1, abort, bus_valid, bus_addr, bus_data,
               bus_last, busy
    );
endinterface

// File: rtl/burst_xfer_ctrl.sv
// Burst transfer controller downstream of a two-requester arbiter.
// Latches the granted requester's start address and length, streams its
// beats onto a shared write bus, pulses done on completion (or abort if
// the grant is withdrawn mid-burst) and then waits for the grant release.
module burst_xfer_ctrl #(
    parameter int DW   = 8,
    parameter int AW   = 8,
    parameter int LENW = 4
) (
    input logic              clock,
    input logic              reset_n,
    burst_xfer_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_XFER0 = 3'd1,
        ST_XFER1 = 3'd2,
        ST_DONE  = 3'd3,
        ST_REL   = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [AW-1:0]   start_r, start_s;
    logic [LENW-1:0] len_r, len_s;
    logic [LENW-1:0] beat_r, beat_s;
    logic            owner_r, owner_s;
    logic            abort_r, abort_s;
    logic            gnt_own_s;
    logic            last_s;
    logic            xfer_s;

    // State and burst-context registers; reset abandons any burst silently.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            start_r <= {AW{1'b0}};
            len_r   <= {LENW{1'b0}};
            beat_r  <= {LENW{1'b0}};
            owner_r <= 1'b0;
            abort_r <= 1'b0;
        end else begin
            state_r <= state_s;
            start_r <= start_s;
            len_r   <= len_s;
            beat_r  <= beat_s;
            owner_r <= owner_s;
            abort_r <= abort_s;
        end
    end

    // Next-state logic: grant pickup, beat counting, completion and release.
    always_comb begin
        state_s   = state_r;
        start_s   = start_r;
        len_s     = len_r;
        beat_s    = beat_r;
        owner_s   = owner_r;
        abort_s   = 1'b0;
        gnt_own_s = owner_r ? bus.gnt_1 : bus.gnt_0;
        last_s    = (beat_r == len_r);
        case (state_r)
            ST_IDLE: begin
                // Requester 0 wins if both grants are (illegally) high.
                if (bus.gnt_0) begin
                    start_s = bus.addr_0;
                    len_s   = bus.len_0;
                    beat_s  = {LENW{1'b0}};
                    owner_s = 1'b0;
                    state_s = ST_XFER0;
                end else if (bus.gnt_1) begin
                    start_s = bus.addr_1;
                    len_s   = bus.len_1;
                    beat_s  = {LENW{1'b0}};
                    owner_s = 1'b1;
                    state_s = ST_XFER1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_XFER0, ST_XFER1: begin
                // A final beat accepted together with a grant drop still
                // completes the burst; otherwise a grant drop aborts it.
                if (bus.bus_ready && last_s) begin
                    state_s = ST_DONE;
                end else if (!gnt_own_s) begin
                    abort_s = 1'b1;
                    state_s = ST_IDLE;
                end else if (bus.bus_ready) begin
                    beat_s = beat_r + {{(LENW-1){1'b0}}, 1'b1};
                end else begin
                    state_s = state_r;
                end
            end
            ST_DONE: begin
                state_s = ST_REL;
            end
            ST_REL: begin
                if (!gnt_own_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REL;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode: bus beat from burst context, data passed through live.
    always_comb begin
        xfer_s        = (state_r == ST_XFER0) || (state_r == ST_XFER1);
        bus.bus_valid = xfer_s;
        bus.bus_last  = xfer_s && last_s;
        bus.rd_0      = (state_r == ST_XFER0) && bus.bus_ready;
        bus.rd_1      = (state_r == ST_XFER1) && bus.bus_ready;
        bus.done_0    = (state_r == ST_DONE) && !owner_r;
        bus.done_1    = (state_r == ST_DONE) && owner_r;
        bus.abort     = abort_r;
        bus.busy      = (state_r != ST_IDLE);
        if (xfer_s) begin
            bus.bus_addr = start_r + AW'(beat_r);
        end else begin
            bus.bus_addr = {AW{1'b0}};
        end
        case (state_r)
            ST_XFER0: bus.bus_data = bus.data_0;
            ST_XFER1: bus.bus_data = bus.data_1;
            default:  bus.bus_data = {DW{1'b0}};
        endcase
    end

endmodule

// File: tb/tb_burst_xfer_ctrl.sv
// Self-checking bench for burst_xfer_ctrl: directed scenarios followed by
// randomized grant/ready/data traffic, all compared cycle by cycle against
// a transaction-level reference model (owner, next address, beats left).
module tb_burst_xfer_ctrl;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    // Reference model: which requester owns the bus and what is pending.
    int   m_owner;      // -1 none, 0 or 1
    bit   m_xfer;       // beats being offered
    int   m_addr;       // address of the current beat
    int   m_left;       // beats still to transfer including current
    bit   m_done_pend;  // done pulse due this cycle
    bit   m_rel;        // waiting for grant release
    bit   m_abort_pend; // abort pulse due this cycle

    burst_xfer_ctrl_if #(.DW(8), .AW(8), .LENW(4)) bif ();

    burst_xfer_ctrl #(.DW(8), .AW(8), .LENW(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = -1; m_xfer = 0; m_addr = 0; m_left = 0;
        m_done_pend = 0; m_rel = 0; m_abort_pend = 0;
    endtask

    task automatic check_outputs();
        int exp_data;
        exp_data = !m_xfer ? 0 : (m_owner == 1 ? int'(bif.data_1) : int'(bif.data_0));
        chk("bus_valid", bif.bus_valid, m_xfer);
        chk("bus_addr",  bif.bus_addr,  m_xfer ? m_addr : 0);
        chk("bus_data",  bif.bus_data,  exp_data);
        chk("bus_last",  bif.bus_last,  m_xfer && m_left == 1);
        chk("rd_0",      bif.rd_0,      m_xfer && m_owner == 0 && bif.bus_ready);
        chk("rd_1",      bif.rd_1,      m_xfer && m_owner == 1 && bif.bus_ready);
        chk("done_0",    bif.done_0,    m_done_pend && m_owner == 0);
        chk("done_1",    bif.done_1,    m_done_pend && m_owner == 1);
        chk("abort",     bif.abort,     m_abort_pend);
        chk("busy",      bif.busy,      m_xfer || m_done_pend || m_rel);
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit g;
        g = (m_owner == 1) ? bif.gnt_1 : bif.gnt_0;
        m_abort_pend = 0;
        if (m_xfer) begin
            if (bif.bus_ready && m_left == 1) begin
                m_xfer = 0; m_done_pend = 1;
            end else if (!g) begin
                m_xfer = 0; m_abort_pend = 1; m_owner = -1;
            end else if (bif.bus_ready) begin
                m_addr = (m_addr + 1) % 256;
                m_left = m_left - 1;
            end
        end else if (m_done_pend) begin
            m_done_pend = 0; m_rel = 1;
        end else if (m_rel) begin
            if (!g) begin
                m_rel = 0; m_owner = -1;
            end
        end else if (bif.gnt_0) begin
            m_owner = 0; m_xfer = 1; m_addr = bif.addr_0; m_left = bif.len_0 + 1;
        end else if (bif.gnt_1) begin
            m_owner = 1; m_xfer = 1; m_addr = bif.addr_1; m_left = bif.len_1 + 1;
        end
    endtask

    // Called at negedge with inputs already driven; returns at next negedge.
    task automatic tick();
        bif.data_0 = 8'($urandom);
        bif.data_1 = 8'($urandom);
        #2;
        check_outputs();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_req(input bit g0, input bit g1, input logic [7:0] a0, input logic [3:0] l0,
                           input logic [7:0] a1, input logic [3:0] l1);
        bif.gnt_0 = g0; bif.gnt_1 = g1;
        bif.addr_0 = a0; bif.len_0 = l0;
        bif.addr_1 = a1; bif.len_1 = l1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        model_reset();
        reset_n = 1'b0;
        bif.bus_ready = 1'b1;
        bif.data_0 = 8'hA5;
        bif.data_1 = 8'h5A;
        set_req(1'b1, 1'b1, 8'h33, 4'd2, 8'h44, 4'd2);
        // Reset state: all outputs zero despite active grants.
        @(negedge clock);
        check_outputs();
        set_req(1'b0, 1'b0, 8'h00, 4'd0, 8'h00, 4'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // T1: single-beat burst on requester 0.
        set_req(1'b1, 1'b0, 8'h10, 4'd0, 8'h00, 4'd0);
        ticks(3);
        bif.gnt_0 = 1'b0;
        ticks(2);

        // T2: four beats with two stall cycles on the second beat.
        set_req(1'b1, 1'b0, 8'h20, 4'd3, 8'h00, 4'd0);
        ticks(2);
        bif.bus_ready = 1'b0;
        ticks(2);
        bif.bus_ready = 1'b1;
        ticks(4);
        bif.gnt_0 = 1'b0;
        ticks(2);

        // T3: requester 1 burst wrapping the address space.
        set_req(1'b0, 1'b1, 8'h00, 4'd0, 8'hFE, 4'd3);
        ticks(6);
        bif.gnt_1 = 1'b0;
        ticks(2);

        // T4: grant dropped after three beats of an eight-beat burst.
        set_req(1'b1, 1'b0, 8'h40, 4'd7, 8'h00, 4'd0);
        ticks(4);
        bif.gnt_0 = 1'b0;
        ticks(3);

        // T5: both grants high, then requester 1 served after release.
        set_req(1'b1, 1'b1, 8'h60, 4'd1, 8'h70, 4'd1);
        ticks(5);
        bif.gnt_0 = 1'b0;
        ticks(6);
        bif.gnt_1 = 1'b0;
        ticks(2);

        // T6: asynchronous reset on the third beat, then a fresh burst.
        set_req(1'b1, 1'b0, 8'h80, 4'd3, 8'h00, 4'd0);
        ticks(3);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clock);
        check_outputs();
        set_req(1'b0, 1'b1, 8'h00, 4'd0, 8'h90, 4'd2);
        reset_n = 1'b1;
        ticks(6);
        bif.gnt_1 = 1'b0;
        ticks(2);

        // Random traffic: sticky grants that occasionally toggle.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) bif.gnt_0 = ~bif.gnt_0;
            if ($urandom_range(0, 9) == 0) bif.gnt_1 = ~bif.gnt_1;
            bif.addr_0 = 8'($urandom);
            bif.addr_1 = 8'($urandom);
            bif.len_0  = 4'($urandom);
            bif.len_1  = 4'($urandom);
            bif.bus_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
